// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared state encodings and decoder constants for the multi-cycle sequencer
package seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_TRAP   = 3'd7
    } seq_state_e;

    localparam logic [1:0] WB_LSU = 2'b01;

    // Branches also select the LSU path, so only loads that write rd count.
    function automatic logic is_mem_op(input logic mem_wren, input logic rd_wren,
                                       input logic [1:0] wb_sel);
        return mem_wren | ((wb_sel == WB_LSU) & rd_wren);
    endfunction

endpackage

// File: rtl/seq_wdt.sv
// rtl/seq_wdt.sv - consecutive unacknowledged memory request cycle counter
module seq_wdt #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_cnt,
    output logic o_expire
);

    localparam int W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [W-1:0] LAST = W'(MEM_TIMEOUT - 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_cnt) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_expire = i_cnt && (r_cnt == LAST);

endmodule

// File: rtl/multicycle_seq.sv
// rtl/multicycle_seq.sv - FETCH/DECODE/EXEC/MEM/WB sequencer sharing one memory port
module multicycle_seq
    import seq_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_halt,
    input  logic             i_imem_ack,
    input  logic             i_dmem_ack,
    input  logic             i_insn_vld,
    input  logic             i_rd_wren,
    input  logic             i_mem_wren,
    input  logic [1:0]       i_wb_sel,
    output logic             o_imem_req,
    output logic             o_ir_en,
    output logic             o_dmem_req,
    output logic             o_dmem_we,
    output logic             o_rd_wren,
    output logic             o_pc_en,
    output logic [2:0]       o_state,
    output logic [CNT_W-1:0] o_instret,
    output logic             o_illegal,
    output logic             o_timeout
);

    seq_state_e       r_state;
    logic [CNT_W-1:0] r_instret;
    logic             r_illegal;
    logic             r_timeout;

    logic w_in_fetch;
    logic w_in_mem;
    logic w_in_wb;
    logic w_wdt_cnt;
    logic w_wdt_clr;
    logic w_expire;

    assign w_in_fetch = (r_state == S_FETCH);
    assign w_in_mem   = (r_state == S_MEM);
    assign w_in_wb    = (r_state == S_WB);

    // Counter is held clear outside the request states, so every entry starts at zero.
    assign w_wdt_clr = !(w_in_fetch || w_in_mem);
    assign w_wdt_cnt = (w_in_fetch && !i_imem_ack) || (w_in_mem && !i_dmem_ack);

    seq_wdt #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_wdt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (w_wdt_clr),
        .i_cnt   (w_wdt_cnt),
        .o_expire(w_expire)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_instret <= '0;
            r_illegal <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_FETCH;
                end
                S_FETCH: begin
                    if (i_imem_ack) begin
                        r_state <= S_DECODE;
                    end else if (w_expire) begin
                        r_state   <= S_TRAP;
                        r_timeout <= 1'b1;
                    end
                end
                S_DECODE: begin
                    if (!i_insn_vld) begin
                        r_state   <= S_TRAP;
                        r_illegal <= 1'b1;
                    end else begin
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_state <= is_mem_op(i_mem_wren, i_rd_wren, i_wb_sel) ? S_MEM : S_WB;
                end
                S_MEM: begin
                    if (i_dmem_ack) begin
                        r_state <= S_WB;
                    end else if (w_expire) begin
                        r_state   <= S_TRAP;
                        r_timeout <= 1'b1;
                    end
                end
                S_WB: begin
                    r_instret <= r_instret + CNT_W'(1);
                    r_state   <= i_halt ? S_HALT : S_FETCH;
                end
                S_HALT: begin
                    if (!i_halt) begin
                        r_state <= S_FETCH;
                    end
                end
                S_TRAP: begin
                    r_state <= S_TRAP;
                end
                default: begin
                    r_state <= S_TRAP;
                end
            endcase
        end
    end

    assign o_imem_req = w_in_fetch;
    assign o_ir_en    = w_in_fetch && i_imem_ack;
    assign o_dmem_req = w_in_mem;
    assign o_dmem_we  = w_in_mem && i_mem_wren;
    assign o_rd_wren  = w_in_wb && i_rd_wren;
    assign o_pc_en    = w_in_wb;
    assign o_state    = r_state;
    assign o_instret  = r_instret;
    assign o_illegal  = r_illegal;
    assign o_timeout  = r_timeout;

endmodule

// File: tb/tb_multicycle_seq.sv
// tb/tb_multicycle_seq.sv - directed per-cycle vector bench for multicycle_seq
module tb_multicycle_seq;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_halt = 1'b0;
    logic       i_imem_ack = 1'b0;
    logic       i_dmem_ack = 1'b0;
    logic       i_insn_vld = 1'b0;
    logic       i_rd_wren = 1'b0;
    logic       i_mem_wren = 1'b0;
    logic [1:0] i_wb_sel = 2'b00;
    logic       o_imem_req, o_ir_en, o_dmem_req, o_dmem_we, o_rd_wren, o_pc_en;
    logic [2:0] o_state;
    logic [3:0] o_instret;
    logic       o_illegal, o_timeout;

    int total = 0;
    int bad = 0;

    multicycle_seq #(
        .MEM_TIMEOUT(4),
        .CNT_W      (4)
    ) dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_halt    (i_halt),
        .i_imem_ack(i_imem_ack),
        .i_dmem_ack(i_dmem_ack),
        .i_insn_vld(i_insn_vld),
        .i_rd_wren (i_rd_wren),
        .i_mem_wren(i_mem_wren),
        .i_wb_sel  (i_wb_sel),
        .o_imem_req(o_imem_req),
        .o_ir_en   (o_ir_en),
        .o_dmem_req(o_dmem_req),
        .o_dmem_we (o_dmem_we),
        .o_rd_wren (o_rd_wren),
        .o_pc_en   (o_pc_en),
        .o_state   (o_state),
        .o_instret (o_instret),
        .o_illegal (o_illegal),
        .o_timeout (o_timeout)
    );

    always #5 i_clk = ~i_clk;

    // Decoder bundles {insn_vld, rd_wren, mem_wren, wb_sel}.
    localparam logic [4:0] ADD = 5'b1_1_0_00;
    localparam logic [4:0] LW  = 5'b1_1_0_01;
    localparam logic [4:0] SW  = 5'b1_0_1_00;
    localparam logic [4:0] BEQ = 5'b1_0_0_01;
    localparam logic [4:0] BAD = 5'b0_0_0_00;

    // Strobes {imem_req, ir_en, dmem_req, dmem_we, rd_wren, pc_en}.
    localparam logic [5:0] NONE = 6'b000000;
    localparam logic [5:0] FREQ = 6'b100000;
    localparam logic [5:0] FACK = 6'b110000;
    localparam logic [5:0] MRD  = 6'b001000;
    localparam logic [5:0] MWR  = 6'b001100;
    localparam logic [5:0] WBW  = 6'b000011;
    localparam logic [5:0] WBN  = 6'b000001;

    typedef struct packed {
        logic        h;
        logic        ia;
        logic        da;
        logic [4:0]  dec;
        logic [14:0] exp;
    } vec_t;

    vec_t tbl[32];

    function automatic vec_t mk(input logic h, input logic ia, input logic da,
                                input logic [4:0] dec, input logic [2:0] st,
                                input logic [5:0] str, input logic [3:0] cnt,
                                input logic ill, input logic to);
        vec_t v;
        v.h   = h;
        v.ia  = ia;
        v.da  = da;
        v.dec = dec;
        v.exp = {st, str, cnt, ill, to};
        return v;
    endfunction

    task automatic drive(input vec_t v);
        i_halt     = v.h;
        i_imem_ack = v.ia;
        i_dmem_ack = v.da;
        {i_insn_vld, i_rd_wren, i_mem_wren, i_wb_sel} = v.dec;
    endtask

    task automatic chk(input string name, input logic [14:0] exp);
        logic [14:0] act;
        act = {o_state, o_imem_req, o_ir_en, o_dmem_req, o_dmem_we, o_rd_wren, o_pc_en,
               o_instret, o_illegal, o_timeout};
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got state=%0d strb=%b cnt=%0d ill=%b to=%b want state=%0d strb=%b cnt=%0d ill=%b to=%b",
                     name, act[14:12], act[11:6], act[5:2], act[1], act[0],
                     exp[14:12], exp[11:6], exp[5:2], exp[1], exp[0]);
        end
    endtask

    task automatic probe(input vec_t v, input string name);
        drive(v);
        #1;
        chk(name, v.exp);
    endtask

    task automatic step(input vec_t v, input string name);
        probe(v, name);
        @(negedge i_clk);
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        drive(mk(0, 0, 0, ADD, 0, NONE, 0, 0, 0));
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    initial begin
        tbl[0]  = mk(0, 0, 0, ADD, 0, NONE, 0, 0, 0);
        tbl[1]  = mk(0, 1, 0, ADD, 1, FACK, 0, 0, 0);
        tbl[2]  = mk(0, 0, 1, ADD, 2, NONE, 0, 0, 0);
        tbl[3]  = mk(0, 0, 1, ADD, 3, NONE, 0, 0, 0);
        tbl[4]  = mk(0, 0, 0, ADD, 5, WBW,  0, 0, 0);
        tbl[5]  = mk(0, 1, 0, LW,  1, FACK, 1, 0, 0);
        tbl[6]  = mk(0, 0, 0, LW,  2, NONE, 1, 0, 0);
        tbl[7]  = mk(0, 0, 0, LW,  3, NONE, 1, 0, 0);
        tbl[8]  = mk(0, 0, 0, LW,  4, MRD,  1, 0, 0);
        tbl[9]  = mk(0, 0, 0, LW,  4, MRD,  1, 0, 0);
        tbl[10] = mk(0, 0, 1, LW,  4, MRD,  1, 0, 0);
        tbl[11] = mk(0, 0, 0, LW,  5, WBW,  1, 0, 0);
        tbl[12] = mk(0, 1, 0, SW,  1, FACK, 2, 0, 0);
        tbl[13] = mk(0, 0, 0, SW,  2, NONE, 2, 0, 0);
        tbl[14] = mk(0, 0, 0, SW,  3, NONE, 2, 0, 0);
        tbl[15] = mk(0, 0, 0, SW,  4, MWR,  2, 0, 0);
        tbl[16] = mk(0, 0, 0, SW,  4, MWR,  2, 0, 0);
        tbl[17] = mk(0, 0, 1, SW,  4, MWR,  2, 0, 0);
        tbl[18] = mk(0, 0, 0, SW,  5, WBN,  2, 0, 0);
        tbl[19] = mk(0, 1, 0, BEQ, 1, FACK, 3, 0, 0);
        tbl[20] = mk(0, 0, 0, BEQ, 2, NONE, 3, 0, 0);
        tbl[21] = mk(0, 0, 0, BEQ, 3, NONE, 3, 0, 0);
        tbl[22] = mk(1, 0, 0, BEQ, 5, WBN,  3, 0, 0);
        tbl[23] = mk(1, 0, 0, BEQ, 6, NONE, 4, 0, 0);
        tbl[24] = mk(1, 1, 1, BEQ, 6, NONE, 4, 0, 0);
        tbl[25] = mk(0, 0, 0, BEQ, 6, NONE, 4, 0, 0);
        tbl[26] = mk(1, 0, 0, ADD, 1, FREQ, 4, 0, 0);
        tbl[27] = mk(1, 1, 0, ADD, 1, FACK, 4, 0, 0);
        tbl[28] = mk(1, 0, 0, ADD, 2, NONE, 4, 0, 0);
        tbl[29] = mk(0, 0, 0, ADD, 3, NONE, 4, 0, 0);
        tbl[30] = mk(0, 0, 0, ADD, 5, WBW,  4, 0, 0);
        tbl[31] = mk(0, 0, 0, ADD, 1, FREQ, 5, 0, 0);

        @(negedge i_clk);
        do_reset();
        for (int i = 0; i < 32; i++) begin
            step(tbl[i], $sformatf("table[%0d]", i));
        end

        // Ack on the 4th request cycle wins, then an illegal opcode traps.
        do_reset();
        step(mk(0, 0, 0, BAD, 0, NONE, 0, 0, 0), "ill_idle");
        for (int i = 0; i < 3; i++) begin
            step(mk(0, 0, 0, BAD, 1, FREQ, 0, 0, 0), $sformatf("ack4_wait%0d", i));
        end
        step(mk(0, 1, 0, BAD, 1, FACK, 0, 0, 0), "ack4_late_ack");
        step(mk(0, 0, 0, BAD, 2, NONE, 0, 0, 0), "ill_decode");
        step(mk(1, 1, 1, ADD, 7, NONE, 0, 1, 0), "ill_trap0");
        step(mk(0, 1, 1, LW,  7, NONE, 0, 1, 0), "ill_trap1");
        step(mk(1, 0, 0, SW,  7, NONE, 0, 1, 0), "ill_trap2");
        i_rst_n = 1'b0;
        probe(mk(0, 0, 0, ADD, 0, NONE, 0, 0, 0), "ill_reset");
        @(negedge i_clk);
        i_rst_n = 1'b1;
        step(mk(0, 0, 0, ADD, 0, NONE, 0, 0, 0), "ill_after_reset");

        // Four unacknowledged fetch cycles.
        do_reset();
        step(mk(0, 0, 0, ADD, 0, NONE, 0, 0, 0), "fto_idle");
        for (int i = 0; i < 4; i++) begin
            step(mk(0, 0, 0, ADD, 1, FREQ, 0, 0, 0), $sformatf("fto_wait%0d", i));
        end
        step(mk(0, 1, 0, ADD, 7, NONE, 0, 0, 1), "fto_trap");
        step(mk(0, 0, 0, ADD, 7, NONE, 0, 0, 1), "fto_trap_hold");

        // Four unacknowledged data cycles on a load.
        do_reset();
        step(mk(0, 0, 0, LW, 0, NONE, 0, 0, 0), "mto_idle");
        step(mk(0, 1, 0, LW, 1, FACK, 0, 0, 0), "mto_fetch");
        step(mk(0, 0, 0, LW, 2, NONE, 0, 0, 0), "mto_decode");
        step(mk(0, 0, 0, LW, 3, NONE, 0, 0, 0), "mto_exec");
        for (int i = 0; i < 4; i++) begin
            step(mk(0, 0, 0, LW, 4, MRD, 0, 0, 0), $sformatf("mto_wait%0d", i));
        end
        step(mk(0, 0, 1, LW, 7, NONE, 0, 0, 1), "mto_trap");

        // Reset during WB kills the write, PC update and count.
        do_reset();
        step(mk(0, 0, 0, ADD, 0, NONE, 0, 0, 0), "abort_idle");
        step(mk(0, 1, 0, ADD, 1, FACK, 0, 0, 0), "abort_fetch");
        step(mk(0, 0, 0, ADD, 2, NONE, 0, 0, 0), "abort_decode");
        step(mk(0, 0, 0, ADD, 3, NONE, 0, 0, 0), "abort_exec");
        probe(mk(0, 0, 0, ADD, 5, WBW, 0, 0, 0), "abort_wb");
        i_rst_n = 1'b0;
        probe(mk(0, 0, 0, ADD, 0, NONE, 0, 0, 0), "abort_in_reset");
        @(negedge i_clk);
        i_rst_n = 1'b1;
        step(mk(0, 0, 0, ADD, 0, NONE, 0, 0, 0), "abort_after");

        // Sixteen back-to-back ADDs wrap the 4-bit counter.
        do_reset();
        step(mk(0, 0, 0, ADD, 0, NONE, 0, 0, 0), "wrap_idle");
        for (int i = 0; i < 16; i++) begin
            step(mk(0, 1, 0, ADD, 1, FACK, 4'(i), 0, 0), $sformatf("wrap_fetch%0d", i));
            step(mk(0, 0, 0, ADD, 2, NONE, 4'(i), 0, 0), $sformatf("wrap_decode%0d", i));
            step(mk(0, 0, 0, ADD, 3, NONE, 4'(i), 0, 0), $sformatf("wrap_exec%0d", i));
            step(mk(0, 0, 0, ADD, 5, WBW,  4'(i), 0, 0), $sformatf("wrap_wb%0d", i));
        end
        step(mk(0, 0, 0, ADD, 1, FREQ, 0, 0, 0), "wrap_zero");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
